// File: rtl/mmu_input_skew.sv
// Input skew feeder for the systolic MMU: delays lane r by r cycles and tracks job progress.
// Optional MMU_SKEW_ZERO_BUBBLE_EN: bubbles carry zero data and inactive lanes are gated to zero.
module mmu_input_skew #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    start,
  input  logic [COUNT_W-1:0]      vec_count,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*WIDTH-1:0]   in_data,
  output logic [ROWS*WIDTH-1:0]   data_out,
  output logic [ROWS-1:0]         active_out,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned DRAIN_W = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 accept;

  assign accept = in_valid && en && (state_q == S_FEED);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    in_ready = 1'b0;
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && en) begin
          cnt_d   = vec_count;
          state_d = (vec_count == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        in_ready = en;
        if (accept) begin
          // Drain ROWS edges so DONE follows the cycle in which the last lane shows its final vector.
          if (cnt_q == COUNT_W'(1)) begin
            drain_d = DRAIN_W'(ROWS);
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (en) begin
          drain_d = drain_q - 1'b1;
          if (drain_q == DRAIN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    localparam int unsigned SW = WIDTH + 1;
    logic [WIDTH-1:0]      lane_in;
    logic [SW-1:0]         entry;
    logic [(r+1)*SW-1:0]   sr;
    logic [SW-1:0]         lane_out;

    assign lane_in = in_data[r*WIDTH +: WIDTH];

    always_comb begin
      if (accept) begin
        entry = {1'b1, lane_in};
      end else begin
`ifdef MMU_SKEW_ZERO_BUBBLE_EN
        entry = '0;
`else
        entry = {1'b0, lane_in};
`endif
      end
    end

    // Packed shift register, newest stage in the low slot; top slot is the output register.
    if (r == 0) begin : g_d1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  sr <= '0;
        else if (en) sr <= entry;
      end
    end else begin : g_dn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  sr <= '0;
        else if (en) sr <= {sr[r*SW-1:0], entry};
      end
    end

    assign lane_out      = sr[r*SW +: SW];
    assign active_out[r] = lane_out[WIDTH];
`ifdef MMU_SKEW_ZERO_BUBBLE_EN
    assign data_out[r*WIDTH +: WIDTH] = lane_out[WIDTH] ? lane_out[WIDTH-1:0] : '0;
`else
    assign data_out[r*WIDTH +: WIDTH] = lane_out[WIDTH-1:0];
`endif
  end

endmodule

// File: tb/tb_mmu_input_skew.sv
// Directed self-checking bench for mmu_input_skew with ROWS=4 and hand-computed lane contents.
module tb_mmu_input_skew;

  localparam int unsigned ROWS    = 4;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned COUNT_W = 16;

  localparam logic [31:0] VEC_A = 32'h04030201;
  localparam logic [31:0] VEC_B = 32'h14131211;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic                  start;
  logic [COUNT_W-1:0]    vec_count;
  logic                  in_valid;
  logic                  in_ready;
  logic [ROWS*WIDTH-1:0] in_data;
  logic [ROWS*WIDTH-1:0] data_out;
  logic [ROWS-1:0]       active_out;
  logic                  busy;
  logic                  done;

  int n_vec = 0;
  int n_err = 0;

  mmu_input_skew #(
    .ROWS    (ROWS),
    .WIDTH   (WIDTH),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .start      (start),
    .vec_count  (vec_count),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .data_out   (data_out),
    .active_out (active_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_cyc(input string tag, input logic [3:0] act, input logic [31:0] dat,
                         input logic dn, input logic bz);
    check({tag, ".act"},  64'(active_out), 64'(act));
    check({tag, ".data"}, 64'(data_out),   64'(dat));
    check({tag, ".done"}, 64'(done),       64'(dn));
    check({tag, ".busy"}, 64'(busy),       64'(bz));
  endtask

  task automatic start_job(input logic [COUNT_W-1:0] n);
    start     = 1'b1;
    vec_count = n;
    tick();
    start     = 1'b0;
    vec_count = '0;
  endtask

  // Two back-to-back vectors; optionally poke start during FEED or stall 3 cycles in DRAIN.
  task automatic b2b(input string tag, input logic poke, input logic stall);
    start_job(2);
    check({tag, ".rdy_feed"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = VEC_A;
    if (poke) begin
      start     = 1'b1;
      vec_count = 16'd5;
    end
    tick();
    exp_cyc({tag, ".k0"}, 4'b0001, 32'h00000001, 1'b0, 1'b1);
    in_data = VEC_B;
    tick();
    start     = 1'b0;
    vec_count = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    exp_cyc({tag, ".k1"}, 4'b0011, 32'h00000211, 1'b0, 1'b1);
    check({tag, ".rdy_drain"}, 64'(in_ready), 64'd0);
    tick();
    exp_cyc({tag, ".k2"}, 4'b0110, 32'h00031200, 1'b0, 1'b1);
    if (stall) begin
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        exp_cyc({tag, ".stall"}, 4'b0110, 32'h00031200, 1'b0, 1'b1);
      end
      en = 1'b1;
    end
    tick();
    exp_cyc({tag, ".k3"}, 4'b1100, 32'h04130000, 1'b0, 1'b1);
    tick();
    exp_cyc({tag, ".k4"}, 4'b1000, 32'h14000000, 1'b0, 1'b1);
    tick();
    exp_cyc({tag, ".k5"}, 4'b0000, 32'h00000000, 1'b1, 1'b1);
    tick();
    exp_cyc({tag, ".k6"}, 4'b0000, 32'h00000000, 1'b0, 1'b0);
    tick();
    exp_cyc({tag, ".k7"}, 4'b0000, 32'h00000000, 1'b0, 1'b0);
    check({tag, ".rdy_idle"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    start     = 1'b0;
    vec_count = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    #12;
    exp_cyc("reset", 4'b0000, 32'h00000000, 1'b0, 1'b0);
    check("reset.rdy", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // in_valid is ignored while idle
    in_valid = 1'b1;
    in_data  = VEC_A;
    tick();
    check("idle.act", 64'(active_out), 64'd0);
    check("idle.rdy", 64'(in_ready),   64'd0);
    check("idle.busy", 64'(busy),      64'd0);
    in_valid = 1'b0;
    in_data  = '0;
    for (int i = 0; i < 4; i++) tick();

    b2b("b2b", 1'b0, 1'b0);
    b2b("poke", 1'b1, 1'b0);
    b2b("stall", 1'b0, 1'b1);

    // Bubble between A and B
    start_job(2);
    in_valid = 1'b1;
    in_data  = VEC_A;
    tick();
    exp_cyc("bub.k0", 4'b0001, 32'h00000001, 1'b0, 1'b1);
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    exp_cyc("bub.k1", 4'b0010, 32'h00000200, 1'b0, 1'b1);
    check("bub.rdy", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = VEC_B;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    exp_cyc("bub.k2", 4'b0101, 32'h00030011, 1'b0, 1'b1);
    tick();
    exp_cyc("bub.k3", 4'b1010, 32'h04001200, 1'b0, 1'b1);
    tick();
    exp_cyc("bub.k4", 4'b0100, 32'h00130000, 1'b0, 1'b1);
    tick();
    exp_cyc("bub.k5", 4'b1000, 32'h14000000, 1'b0, 1'b1);
    tick();
    exp_cyc("bub.k6", 4'b0000, 32'h00000000, 1'b1, 1'b1);
    tick();
    exp_cyc("bub.k7", 4'b0000, 32'h00000000, 1'b0, 1'b0);

    // Empty job
    start_job(0);
    exp_cyc("n0.s1", 4'b0000, 32'h00000000, 1'b1, 1'b1);
    check("n0.rdy", 64'(in_ready), 64'd0);
    tick();
    exp_cyc("n0.s2", 4'b0000, 32'h00000000, 1'b0, 1'b0);

    // Asynchronous reset mid-FEED with all lanes active
    start_job(5);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = (i % 2 == 0) ? VEC_A : VEC_B;
      tick();
    end
    check("rst.full", 64'(active_out), 64'hF);
    #3;
    rst_n = 1'b0;
    #1;
    exp_cyc("rst.async", 4'b0000, 32'h00000000, 1'b0, 1'b0);
    check("rst.rdy", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    in_data  = '0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_cyc("rst.after", 4'b0000, 32'h00000000, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
